// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480 timing constants and the coordinate type
// shared by the VGA timing generator and its users.
package vga_timing_pkg;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_CLK_DIV  = 2;
    localparam int VGA_COORD_W  = 10;

    typedef logic [VGA_COORD_W-1:0] coord_t;
endpackage

// File: rtl/pix_div.sv
// pix_div: divides Clk down to a one-cycle pixel enable every CLK_DIV cycles.
// The count only moves while run is high, so a pause resumes mid-period.
module pix_div #(
    parameter int CLK_DIV = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic run,
    output logic pix_en
);
    localparam int             DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]  LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;

    // Next divider count: wrap at LAST, hold while paused.
    always_comb begin
        div_d = div_q;
        if (run) begin
            div_d = (div_q == LAST) ? '0 : div_q + 1'b1;
        end
    end

    // Divider register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // With CLK_DIV=1 the compare is always true, so pix_en follows run.
    assign pix_en = run && (div_q == LAST);
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (sync, blank, coordinates, line/frame
// pulses). Define VGA_TIMING_PREFETCH_EN to add NextX/NextY, the position one
// pixel ahead, for sprite ROMs with one pixel of read latency.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int CLK_DIV  = VGA_CLK_DIV,
    parameter bit SYNC_POL = 1'b0,
    parameter int COORD_W  = VGA_COORD_W
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               run,
    output logic               pix_en,
    output logic [COORD_W-1:0] DrawX,
    output logic [COORD_W-1:0] DrawY,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_BLANK_N,
    output logic               VGA_SYNC_N,
    output logic               frame_start,
`ifdef VGA_TIMING_PREFETCH_EN
    output logic               line_start,
    output logic [COORD_W-1:0] NextX,
    output logic [COORD_W-1:0] NextY
`else
    output logic               line_start
`endif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
    logic               hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
    logic               fs_q, fs_d, ls_q, ls_d;

    pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
        .Clk    (Clk),
        .Reset  (Reset),
        .run    (run),
        .pix_en (pix_en)
    );

    // Raster position: h advances per pixel, v advances on the h wrap.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_en) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Decode the position the outputs will show next cycle, so every output
    // register lines up with DrawX/DrawY. Pulses only fire on a pixel step.
    always_comb begin
        hs_d    = ((h_d >= HS_FIRST) && (h_d <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
        vs_d    = ((v_d >= VS_FIRST) && (v_d <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
        blank_d = (h_d < H_ACT_C) && (v_d < V_ACT_C);
        ls_d    = pix_en && (h_d == '0);
        fs_d    = ls_d && (v_d == '0);
    end

    // Output registers; reset parks at the last pixel so the first step lands on (0,0).
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            h_q     <= H_LAST;
            v_q     <= V_LAST;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
            blank_q <= 1'b0;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            fs_q    <= fs_d;
            ls_q    <= ls_d;
        end
    end

    assign DrawX       = h_q;
    assign DrawY       = v_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_q;
    assign VGA_SYNC_N  = 1'b0;
    assign frame_start = fs_q;
    assign line_start  = ls_q;

`ifdef VGA_TIMING_PREFETCH_EN
    logic [COORD_W-1:0] nx_q, nx_d, ny_q, ny_d;

    // One pixel ahead of the next displayed position, wrapping like h/v.
    always_comb begin
        nx_d = h_d + 1'b1;
        ny_d = v_d;
        if (h_d == H_LAST) begin
            nx_d = '0;
            ny_d = (v_d == V_LAST) ? '0 : v_d + 1'b1;
        end
    end

    // Look-ahead registers, updated together with DrawX/DrawY.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            nx_q <= '0;
            ny_q <= '0;
        end else begin
            nx_q <= nx_d;
            ny_q <= ny_d;
        end
    end

    assign NextX = nx_q;
    assign NextY = ny_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of the VGA timing generator. A default
// 640x480 instance covers reset, line timing, pause and mid-frame reset; a
// small 16x8 instance with CLK_DIV=1 and active-high syncs covers full frames.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // default-parameter instance
    logic   rst, run;
    logic   pix_en, hs, vs, blank_n, sync_n, fs, ls;
    coord_t dx, dy;
    // small instance: H 8+2+3+3=16, V 4+1+1+2=8, CLK_DIV=1, SYNC_POL=1
    logic   rst_s, run_s;
    logic   pix_en_s, hs_s, vs_s, blank_n_s, sync_n_s, fs_s, ls_s;
    coord_t dx_s, dy_s;
`ifdef VGA_TIMING_PREFETCH_EN
    coord_t nx, ny, nx_s, ny_s;
`endif

    vga_timing_gen dut (
        .Clk(clk), .Reset(rst), .run(run), .pix_en(pix_en),
        .DrawX(dx), .DrawY(dy), .VGA_HS(hs), .VGA_VS(vs),
        .VGA_BLANK_N(blank_n), .VGA_SYNC_N(sync_n),
        .frame_start(fs),
`ifdef VGA_TIMING_PREFETCH_EN
        .line_start(ls), .NextX(nx), .NextY(ny)
`else
        .line_start(ls)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .CLK_DIV(1), .SYNC_POL(1'b1)
    ) dut_s (
        .Clk(clk), .Reset(rst_s), .run(run_s), .pix_en(pix_en_s),
        .DrawX(dx_s), .DrawY(dy_s), .VGA_HS(hs_s), .VGA_VS(vs_s),
        .VGA_BLANK_N(blank_n_s), .VGA_SYNC_N(sync_n_s),
        .frame_start(fs_s),
`ifdef VGA_TIMING_PREFETCH_EN
        .line_start(ls_s), .NextX(nx_s), .NextY(ny_s)
`else
        .line_start(ls_s)
`endif
    );

    task automatic test_reset();
        rst = 1'b1; run = 1'b1; rst_s = 1'b1; run_s = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (dx !== 10'd799 || dy !== 10'd524) begin
            failures++; $display("FAIL reset_pos got=(%0d,%0d) exp=(799,524)", dx, dy);
        end
        checks++;
        if ({hs, vs, blank_n, sync_n} !== 4'b1100) begin
            failures++; $display("FAIL reset_levels hs/vs/blank/sync got=%b exp=1100", {hs, vs, blank_n, sync_n});
        end
        checks++;
        if ({pix_en, fs, ls} !== 3'b000) begin
            failures++; $display("FAIL reset_pulses pix/fs/ls got=%b exp=000", {pix_en, fs, ls});
        end
        checks++;
        if (dx_s !== 10'd15 || dy_s !== 10'd7 || {hs_s, vs_s, blank_n_s, sync_n_s} !== 4'b0000) begin
            failures++; $display("FAIL reset_small got=(%0d,%0d) lv=%b exp=(15,7) lv=0000",
                                 dx_s, dy_s, {hs_s, vs_s, blank_n_s, sync_n_s});
        end
`ifdef VGA_TIMING_PREFETCH_EN
        checks++;
        if (nx !== 10'd0 || ny !== 10'd0) begin
            failures++; $display("FAIL reset_next got=(%0d,%0d) exp=(0,0)", nx, ny);
        end
`endif
    endtask

    task automatic test_startup();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (pix_en !== 1'b1 || dx !== 10'd799) begin
            failures++; $display("FAIL startup_div got pix_en=%b x=%0d exp pix_en=1 x=799", pix_en, dx);
        end
        @(negedge clk);
        checks++;
        if (dx !== 10'd0 || dy !== 10'd0 || {fs, ls, blank_n, pix_en} !== 4'b1110) begin
            failures++; $display("FAIL startup_first got=(%0d,%0d) fs/ls/blank/pix=%b exp=(0,0) 1110",
                                 dx, dy, {fs, ls, blank_n, pix_en});
        end
`ifdef VGA_TIMING_PREFETCH_EN
        checks++;
        if (nx !== 10'd1 || ny !== 10'd0) begin
            failures++; $display("FAIL startup_next got=(%0d,%0d) exp=(1,0)", nx, ny);
        end
`endif
    endtask

    task automatic test_line();
        int npix = 0, nhs = 0, first_hs = -1, last_hs = -1, bad_blank = 0, bad_fs = 0;
        bit seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (ls) begin
                seen = 1'b1;
            end else begin
                if (pix_en) npix++;
                if (pix_en && hs == 1'b0) begin
                    nhs++;
                    if (first_hs < 0) first_hs = int'(dx);
                    last_hs = int'(dx);
                end
                if (blank_n !== (dx < 10'd640)) bad_blank++;
                if (fs !== 1'b0) bad_fs++;
            end
        end
        checks++;
        if (!seen) begin
            failures++; $display("FAIL line_timeout got=no line_start exp=line_start within 2000 clk");
        end
        checks++;
        if (npix != 800) begin
            failures++; $display("FAIL line_pix_count got=%0d exp=800", npix);
        end
        checks++;
        if (nhs != 96 || first_hs != 656 || last_hs != 751) begin
            failures++; $display("FAIL line_hsync got=%0d px %0d..%0d exp=96 px 656..751", nhs, first_hs, last_hs);
        end
        checks++;
        if (bad_blank != 0 || bad_fs != 0) begin
            failures++; $display("FAIL line_blank_fs got=%0d/%0d bad samples exp=0/0", bad_blank, bad_fs);
        end
        checks++;
        if (dx !== 10'd0 || dy !== 10'd1) begin
            failures++; $display("FAIL line_wrap got=(%0d,%0d) exp=(0,1)", dx, dy);
        end
    endtask

    task automatic test_run_pause();
        bit hit = 1'b0;
        int bad = 0;
        for (int c = 0; c < 1000 && !hit; c++) begin
            @(negedge clk);
            if (dx == 10'd300 && pix_en) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            failures++; $display("FAIL pause_reach got=x%0d exp=x300 with pix_en", dx);
        end
        run = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (dx !== 10'd300 || dy !== 10'd1 || {pix_en, fs, ls, hs, blank_n} !== 5'b00011) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL pause_hold got=%0d bad cycles exp=0", bad);
        end
        run = 1'b1;
        #1;
        checks++;
        if (pix_en !== 1'b1) begin
            failures++; $display("FAIL pause_div_held got pix_en=%b exp=1", pix_en);
        end
        @(negedge clk);
        checks++;
        if (dx !== 10'd301 || dy !== 10'd1) begin
            failures++; $display("FAIL pause_resume got=(%0d,%0d) exp=(301,1)", dx, dy);
        end
    endtask

    task automatic test_reset_midframe();
        bit hit = 1'b0;
        for (int c = 0; c < 1000 && !hit; c++) begin
            @(negedge clk);
            if (dx == 10'd700) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            failures++; $display("FAIL midrst_reach got=x%0d exp=x700", dx);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (dx !== 10'd799 || dy !== 10'd524 || {hs, vs, blank_n, pix_en, fs, ls} !== 6'b110000) begin
            failures++; $display("FAIL midrst_async got=(%0d,%0d) lv=%b exp=(799,524) lv=110000",
                                 dx, dy, {hs, vs, blank_n, pix_en, fs, ls});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (dx !== 10'd0 || dy !== 10'd0 || {fs, ls} !== 2'b11) begin
            failures++; $display("FAIL midrst_first got=(%0d,%0d) fs/ls=%b exp=(0,0) 11", dx, dy, {fs, ls});
        end
    endtask

    task automatic test_small_frame();
        int px = 0, py = 0, npix = 0, nvs = 0, nhs = 0, bad_pos = 0, bad_lv = 0, bad_pe = 0;
        int bad_next = 0;
        bit seen = 1'b0;
        rst_s = 1'b0;
        #1;
        checks++;
        if (pix_en_s !== 1'b1) begin
            failures++; $display("FAIL div1_first_pix got=%b exp=1", pix_en_s);
        end
        @(negedge clk);
        checks++;
        if (dx_s !== 10'd0 || dy_s !== 10'd0 || {fs_s, ls_s} !== 2'b11) begin
            failures++; $display("FAIL div1_start got=(%0d,%0d) fs/ls=%b exp=(0,0) 11", dx_s, dy_s, {fs_s, ls_s});
        end
        for (int c = 0; c < 400 && !seen; c++) begin
            if (pix_en_s) npix++; else bad_pe++;
            if (int'(dx_s) != px || int'(dy_s) != py) bad_pos++;
            if (vs_s) nvs++;
            if (hs_s) nhs++;
            if (vs_s !== (py == 5) || hs_s !== (px >= 10 && px <= 12) ||
                blank_n_s !== (px < 8 && py < 4)) bad_lv++;
`ifdef VGA_TIMING_PREFETCH_EN
            if (int'(nx_s) != ((px == 15) ? 0 : px + 1) ||
                int'(ny_s) != ((px == 15) ? ((py == 7) ? 0 : py + 1) : py)) bad_next++;
`endif
            if (px == 15) begin px = 0; py = (py == 7) ? 0 : py + 1; end
            else px++;
            @(negedge clk);
            if (fs_s) seen = 1'b1;
        end
        checks++;
        if (!seen || npix != 128 || bad_pe != 0) begin
            failures++; $display("FAIL div1_frame got seen=%0d pix=%0d gaps=%0d exp seen=1 pix=128 gaps=0",
                                 seen, npix, bad_pe);
        end
        checks++;
        if (bad_pos != 0) begin
            failures++; $display("FAIL div1_position got=%0d bad exp=0", bad_pos);
        end
        checks++;
        if (nvs != 16 || nhs != 24 || bad_lv != 0) begin
            failures++; $display("FAIL div1_syncs got vs=%0d hs=%0d bad=%0d exp vs=16 hs=24 bad=0", nvs, nhs, bad_lv);
        end
        checks++;
        if (bad_next != 0) begin
            failures++; $display("FAIL div1_next got=%0d bad exp=0", bad_next);
        end
    endtask

    task automatic test_pause_pulse();
        int bad = 0;
        run_s = 1'b0;
        #1;
        checks++;
        if (pix_en_s !== 1'b0) begin
            failures++; $display("FAIL pulse_pix_drop got=%b exp=0", pix_en_s);
        end
        repeat (5) begin
            @(negedge clk);
            if ({fs_s, ls_s} !== 2'b00 || dx_s !== 10'd0 || dy_s !== 10'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL pulse_no_repeat got=%0d bad cycles exp=0", bad);
        end
        run_s = 1'b1;
        @(negedge clk);
        checks++;
        if (dx_s !== 10'd1 || dy_s !== 10'd0 || ls_s !== 1'b0) begin
            failures++; $display("FAIL pulse_resume got=(%0d,%0d) ls=%b exp=(1,0) ls=0", dx_s, dy_s, ls_s);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_line();
        test_run_pause();
        test_reset_midframe();
        test_small_frame();
        test_pause_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
